mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 6 +
 rtl/mem_array.sv | 23 ++
 rtl/mem_responder.sv | 104 ++++++++++
 tb/tb_mem_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared bus widths and FSM state encodings for mem_responder.
package mem_responder_pkg;
   localparam int ADDR_LEN = 32;
   localparam int DATA_LEN = 32;
   typedef enum logic [1:0] {MEM_ST_IDLE, MEM_ST_WAIT, MEM_ST_RESP} mem_state_e;
endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x DATA_LEN storage, synchronous write, combinational read, synchronous clear.
module mem_array
   import mem_responder_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [IDX_W-1:0]    idx,
   input  logic [DATA_LEN-1:0] wdata,
   output logic [DATA_LEN-1:0] rdata
);
   logic [DATA_LEN-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      else if (we) mem_q[idx] <= wdata;
   end

   assign rdata = mem_q[idx];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with fixed access latency.
// Define MEM_ERR_CHECK_EN to flag misaligned or out-of-range accesses via resp_err.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic                req_write,
   input  logic [ADDR_LEN-1:0] req_addr,
   input  logic [DATA_LEN-1:0] req_wdata,
   output logic                req_ready,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_LEN-1:0] resp_rdata,
   output logic                resp_err,
   output logic                busy
);
   localparam int IDX_W = $clog2(DEPTH);

   mem_state_e          state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_LEN-1:0] addr_q, addr_d, acc_addr;
   logic [DATA_LEN-1:0] wdata_q, wdata_d, rdata_q, rdata_d, acc_wdata, rd;
   logic                write_q, write_d, err_q, err_d, acc_write;
   logic                accept, access, bad, we;

`ifdef MEM_ERR_CHECK_EN
   assign bad = acc_addr[1:0] != 2'b00 || (acc_addr >> (IDX_W + 2)) != '0;
`else
   logic unused_addr;
   assign bad = 1'b0;
   assign unused_addr = ^{acc_addr[ADDR_LEN-1:IDX_W+2], acc_addr[1:0]};
`endif

   always_comb begin
      accept    = state_q == MEM_ST_IDLE && req_valid;
      access    = (accept && LATENCY == 0) || (state_q == MEM_ST_WAIT && cnt_q == 4'd0);
      // with zero latency the access happens on the acceptance edge, before capture
      acc_addr  = state_q == MEM_ST_IDLE ? req_addr : addr_q;
      acc_wdata = state_q == MEM_ST_IDLE ? req_wdata : wdata_q;
      acc_write = state_q == MEM_ST_IDLE ? req_write : write_q;
      we        = access && acc_write && !bad;
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      write_d   = write_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      if (accept) begin
         addr_d  = req_addr;
         wdata_d = req_wdata;
         write_d = req_write;
         state_d = MEM_ST_WAIT;
         cnt_d   = LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);
      end
      if (state_q == MEM_ST_WAIT) cnt_d = access ? 4'd0 : cnt_q - 4'd1;
      if (access) begin
         state_d = MEM_ST_RESP;
         rdata_d = bad ? '0 : acc_write ? acc_wdata : rd;
         err_d   = bad;
      end
      if (state_q == MEM_ST_RESP && resp_ready) state_d = MEM_ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MEM_ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   mem_array #(.DEPTH(DEPTH)) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .idx   (acc_addr[IDX_W+1:2]),
      .wdata (acc_wdata),
      .rdata (rd)
   );

   assign req_ready  = state_q == MEM_ST_IDLE;
   assign resp_valid = state_q == MEM_ST_RESP;
   assign busy       = state_q != MEM_ST_IDLE;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder at LATENCY=2 (dut2) and LATENCY=0 (dut0).
module tb_mem_responder;
   logic        clk = 1'b0, rst = 1'b1, rv2 = 1'b0, rv0 = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        ready2, rvalid2, err2, busy2, ready0, rvalid0, err0, busy0;
   logic [31:0] rdata2, rdata0;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH(256), .LATENCY(2)) dut2 (
      .clk(clk), .rst(rst), .req_valid(rv2), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(ready2), .resp_valid(rvalid2), .resp_ready(resp_ready),
      .resp_rdata(rdata2), .resp_err(err2), .busy(busy2)
   );

   mem_responder #(.DEPTH(256), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(rv0), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(ready0), .resp_valid(rvalid0), .resp_ready(resp_ready),
      .resp_rdata(rdata0), .resp_err(err0), .busy(busy0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // lat counts cycles from the acceptance cycle to the first cycle with resp_valid
   task automatic xact(input bit z, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic e);
      int n;
      n = 0;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      if (z) rv0 = 1'b1; else rv2 = 1'b1;
      while (!(z ? ready0 : ready2) && n < 50) begin
         tick();
         n++;
      end
      tick();
      rv0 = 1'b0;
      rv2 = 1'b0;
      lat = 1;
      while (!(z ? rvalid0 : rvalid2) && lat < 50) begin
         tick();
         lat++;
      end
      rd = z ? rdata0 : rdata2;
      e  = z ? err0 : err2;
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", ready2); end
      checks++; if (rvalid2 !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", rvalid2); end
      checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata2); end
      checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err2); end
      checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy2); end
      checks++; if (ready0 !== 1'b1 || rvalid0 !== 1'b0 || busy0 !== 1'b0) begin
         errors++; $display("FAIL reset_dut0 got ready=%b valid=%b busy=%b exp 1 0 0", ready0, rvalid0, busy0);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_store_load();
      int lat; logic [31:0] rd; logic e;
      xact(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, e);
      checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency got %0d exp 3", lat); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL store_rdata got %h exp deadbeef", rd); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL store_err got %b exp 0", e); end
      xact(0, 1'b0, 32'h10, 32'h0, lat, rd, e);
      checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d exp 3", lat); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got %h exp deadbeef", rd); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL load_err got %b exp 0", e); end
   endtask

   task automatic test_latency0();
      int lat; logic [31:0] rd; logic e;
      xact(1, 1'b0, 32'h0, 32'h0, lat, rd, e);
      checks++; if (lat !== 1) begin errors++; $display("FAIL lat0_latency got %0d exp 1", lat); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL lat0_load_rdata got %h exp 0", rd); end
      xact(1, 1'b1, 32'h8, 32'h11223344, lat, rd, e);
      checks++; if (lat !== 1 || rd !== 32'h11223344) begin
         errors++; $display("FAIL lat0_store got lat=%0d rdata=%h exp 1 11223344", lat, rd);
      end
      xact(1, 1'b0, 32'h8, 32'h0, lat, rd, e);
      checks++; if (rd !== 32'h11223344 || e !== 1'b0) begin
         errors++; $display("FAIL lat0_reload got rdata=%h err=%b exp 11223344 0", rd, e);
      end
   endtask

   task automatic test_backpressure();
      int n;
      n = 0;
      req_write = 1'b0;
      req_addr  = 32'h10;
      rv2 = 1'b1;
      tick();
      rv2 = 1'b0;
      while (!rvalid2 && n < 20) begin
         tick();
         n++;
      end
      checks++; if (rvalid2 !== 1'b1) begin errors++; $display("FAIL bp_timeout got valid=%b exp 1", rvalid2); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rvalid2 !== 1'b1 || rdata2 !== 32'hDEADBEEF || ready2 !== 1'b0 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got valid=%b rdata=%h ready=%b busy=%b exp 1 deadbeef 0 1",
                     i, rvalid2, rdata2, ready2, busy2);
         end
         tick();
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      checks++; if (rvalid2 !== 1'b0 || ready2 !== 1'b1 || busy2 !== 1'b0) begin
         errors++; $display("FAIL bp_release got valid=%b ready=%b busy=%b exp 0 1 0", rvalid2, ready2, busy2);
      end
   endtask

   task automatic test_wait_reset();
      int lat; logic [31:0] rd; logic e;
      req_write = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'h12345678;
      rv2 = 1'b1;
      tick();
      rv2 = 1'b0;
      checks++; if (busy2 !== 1'b1 || rvalid2 !== 1'b0) begin
         errors++; $display("FAIL wrst_in_wait got busy=%b valid=%b exp 1 0", busy2, rvalid2);
      end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (ready2 !== 1'b1 || busy2 !== 1'b0 || rvalid2 !== 1'b0) begin
         errors++; $display("FAIL wrst_idle got ready=%b busy=%b valid=%b exp 1 0 0", ready2, busy2, rvalid2);
      end
      xact(0, 1'b0, 32'h20, 32'h0, lat, rd, e);
      checks++; if (rd !== 32'h0 || lat !== 3) begin
         errors++; $display("FAIL wrst_no_store got rdata=%h lat=%0d exp 0 3", rd, lat);
      end
      xact(0, 1'b0, 32'h10, 32'h0, lat, rd, e);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wrst_array_clear got %h exp 0", rd); end
   endtask

   task automatic test_addr_map();
      int lat; logic [31:0] rd; logic e;
`ifdef MEM_ERR_CHECK_EN
      xact(0, 1'b1, 32'h402, 32'h1111, lat, rd, e);
      checks++; if (e !== 1'b1 || rd !== 32'h0 || lat !== 3) begin
         errors++; $display("FAIL err_misaligned got err=%b rdata=%h lat=%0d exp 1 0 3", e, rd, lat);
      end
      xact(0, 1'b1, 32'h400, 32'h2222, lat, rd, e);
      checks++; if (e !== 1'b1 || rd !== 32'h0) begin
         errors++; $display("FAIL err_range got err=%b rdata=%h exp 1 0", e, rd);
      end
      xact(0, 1'b0, 32'h0, 32'h0, lat, rd, e);
      checks++; if (e !== 1'b0 || rd !== 32'h0) begin
         errors++; $display("FAIL err_no_store got err=%b rdata=%h exp 0 0", e, rd);
      end
`else
      xact(0, 1'b1, 32'h404, 32'hA5, lat, rd, e);
      checks++; if (e !== 1'b0 || rd !== 32'hA5) begin
         errors++; $display("FAIL wrap_store got err=%b rdata=%h exp 0 a5", e, rd);
      end
      xact(0, 1'b0, 32'h4, 32'h0, lat, rd, e);
      checks++; if (e !== 1'b0 || rd !== 32'hA5) begin
         errors++; $display("FAIL wrap_load got err=%b rdata=%h exp 0 a5", e, rd);
      end
      xact(0, 1'b0, 32'h7, 32'h0, lat, rd, e);
      checks++; if (e !== 1'b0 || rd !== 32'hA5) begin
         errors++; $display("FAIL low_bits_ignored got err=%b rdata=%h exp 0 a5", e, rd);
      end
`endif
   endtask

   task automatic test_ignore();
      int lat, n; logic [31:0] rd; logic e;
      n = 0;
      req_write = 1'b1;
      req_addr  = 32'h30;
      req_wdata = 32'hCAFEF00D;
      rv2 = 1'b1;
      tick();
      while (!rvalid2 && n < 20) begin
         rv2 = ~rv2;
         req_addr  = 32'h34 + 32'(n * 4);
         req_wdata = 32'(n);
         req_write = n[0];
         tick();
         n++;
      end
      rv2 = 1'b1;
      req_addr = 32'h38;
      tick();
      checks++; if (rvalid2 !== 1'b1 || rdata2 !== 32'hCAFEF00D || err2 !== 1'b0) begin
         errors++; $display("FAIL ign_resp got valid=%b rdata=%h err=%b exp 1 cafef00d 0", rvalid2, rdata2, err2);
      end
      rv2 = 1'b0;
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL ign_idle got ready=%b exp 1", ready2); end
      xact(0, 1'b0, 32'h30, 32'h0, lat, rd, e);
      checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL ign_reload got %h exp cafef00d", rd); end
      xact(0, 1'b0, 32'h34, 32'h0, lat, rd, e);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ign_no_stray got %h exp 0", rd); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] rd; logic e;
      xact(0, 1'b1, 32'h40, 32'h00000001, lat, rd, e);
      checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", ready2); end
      xact(0, 1'b0, 32'h40, 32'h0, lat, rd, e);
      checks++; if (rd !== 32'h1 || lat !== 3) begin
         errors++; $display("FAIL b2b_load got rdata=%h lat=%0d exp 1 3", rd, lat);
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_latency0();
      test_backpressure();
      test_wait_reset();
      test_addr_map();
      test_ignore();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
